// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared FSM encoding and default windows for the button debouncer
package btn_pkg;

  typedef enum logic [1:0] {
    RELEASED    = 2'b00,
    ARM_PRESS   = 2'b01,
    PRESSED     = 2'b10,
    ARM_RELEASE = 2'b11
  } btn_fsm_e;

  localparam int DEF_LOG2DEBOUNCE = 16;
  localparam int DEF_LOG2LONG     = 23;

endpackage

// File: rtl/button_debounce_ch.sv
// rtl/button_debounce_ch.sv - one button channel: 2-flop sync, debounce FSM, optional hold counter
// Optional feature: LONG_PRESS_EN adds the long-press hold counter and btn_long pulse.
module button_debounce_ch
  import btn_pkg::*;
#(
  parameter int   LOG2DEBOUNCE = DEF_LOG2DEBOUNCE,
  parameter int   LOG2LONG     = DEF_LOG2LONG,
  parameter logic ACTIVE_LOW   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic state_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  // The entry sample counts as the first of the window, so the FSM needs
  // 2**LOG2DEBOUNCE consecutive equal samples and exits one count early.
  localparam logic [LOG2DEBOUNCE-1:0] CNT_LAST = {{(LOG2DEBOUNCE-1){1'b1}}, 1'b0};

  logic                    sync1_q, sync2_q;
  logic                    s;
  btn_fsm_e                state_q, state_d;
  logic [LOG2DEBOUNCE-1:0] cnt_q, cnt_d;
  logic                    press_q, press_d;
  logic                    release_q, release_d;

  assign s = sync2_q ^ ACTIVE_LOW;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= ACTIVE_LOW;
      sync2_q   <= ACTIVE_LOW;
      state_q   <= RELEASED;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= raw_i;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      RELEASED: begin
        if (s) begin
          state_d = ARM_PRESS;
          cnt_d   = '0;
        end
      end
      ARM_PRESS: begin
        if (!s) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = ARM_RELEASE;
          cnt_d   = '0;
        end
      end
      ARM_RELEASE: begin
        if (s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = RELEASED;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  assign state_o   = (state_q == PRESSED) || (state_q == ARM_RELEASE);
  assign press_o   = press_q;
  assign release_o = release_q;

`ifdef LONG_PRESS_EN
  localparam logic [LOG2LONG-1:0] HCNT_MAX = '1;

  logic [LOG2LONG-1:0] hcnt_q, hcnt_d;
  logic                fired_q, fired_d;
  logic                long_q, long_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q  <= '0;
      fired_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      hcnt_q  <= hcnt_d;
      fired_q <= fired_d;
      long_q  <= long_d;
    end
  end

  // Only a fresh press restarts the hold; release bounce back to PRESSED keeps counting.
  always_comb begin
    hcnt_d  = hcnt_q;
    fired_d = fired_q;
    long_d  = 1'b0;
    if (state_q == ARM_PRESS && state_d == PRESSED) begin
      hcnt_d  = '0;
      fired_d = 1'b0;
    end else if (state_o) begin
      if (hcnt_q != HCNT_MAX) begin
        hcnt_d = hcnt_q + 1'b1;
      end else if (!fired_q) begin
        long_d  = 1'b1;
        fired_d = 1'b1;
      end
    end
  end

  assign long_o = long_q;
`else
  if (LOG2LONG > 0) begin : g_no_long
    assign long_o = 1'b0;
  end else begin : g_no_long_w0
    assign long_o = 1'b0;
  end
`endif

endmodule

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - N-channel synchronising push-button debouncer with press/release pulses
// Optional feature: define LONG_PRESS_EN for per-channel long-press pulses on btn_long.
module button_debounce
  import btn_pkg::*;
#(
  parameter int               N_BTN        = 3,
  parameter int               LOG2DEBOUNCE = DEF_LOG2DEBOUNCE,
  parameter logic [N_BTN-1:0] ACTIVE_LOW   = 3'b001,
  parameter int               LOG2LONG     = DEF_LOG2LONG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_state,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    button_debounce_ch #(
      .LOG2DEBOUNCE(LOG2DEBOUNCE),
      .LOG2LONG    (LOG2LONG),
      .ACTIVE_LOW  (ACTIVE_LOW[i])
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .raw_i    (btn_raw[i]),
      .state_o  (btn_state[i]),
      .press_o  (btn_press[i]),
      .release_o(btn_release[i]),
      .long_o   (btn_long[i])
    );
  end

endmodule
